// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor history parameters and types
package bp_pkg;
    localparam int DEF_GHR_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    typedef logic [DEF_GHR_WIDTH-1:0] ghr_t;
    typedef logic [$clog2(DEF_DEPTH)-1:0] ckpt_tag_t;
endpackage

// File: rtl/ghr_ckpt_buf.sv
// ghr_ckpt_buf: per-branch history checkpoints, one write port, async read
module ghr_ckpt_buf import bp_pkg::*; #(
    parameter  int W     = DEF_GHR_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [TAG_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [TAG_W-1:0] raddr,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/ghr_reg.sv
// ghr_reg: shift-left history register, newest outcome enters at bit 0
module ghr_reg import bp_pkg::*; #(
    parameter int W = DEF_GHR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (shift_en) q <= {q[W-2:0], din};
endmodule

// File: rtl/ghr_ctrl.sv
// ghr_ctrl: speculative/architectural global history with mispredict checkpoint restore
module ghr_ctrl import bp_pkg::*; #(
    parameter  int GHR_WIDTH = DEF_GHR_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    localparam int TAG_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    output logic                 pred_ready,
    output logic [TAG_W-1:0]     pred_tag,
    input  logic                 resolve_valid,
    input  logic [TAG_W-1:0]     resolve_tag,
    input  logic                 resolve_mispredict,
    input  logic                 resolve_taken,
    input  logic                 commit_valid,
    input  logic                 commit_taken,
    input  logic                 flush_all,
    output logic [GHR_WIDTH-1:0] ghr_spec,
    output logic [GHR_WIDTH-1:0] ghr_arch,
    output logic [TAG_W:0]       ckpt_count,
    output logic                 full,
    output logic                 empty
);
    localparam int CW = TAG_W + 1;
    logic [TAG_W-1:0] head, tail, head_nx, tail_nx, tag_dist;
    logic [CW-1:0] count, count_nx;
    logic [GHR_WIDTH-1:0] ghr_spec_nx, arch_nx, ckpt_rd;
    logic mispredict, push, pop;
    assign pred_tag = tail;
    assign ckpt_count = count;
    always_comb begin
        mispredict = resolve_valid && resolve_mispredict;
        pred_ready = !full && !mispredict && !flush_all;
        push = pred_valid && pred_ready;
        pop = commit_valid && !empty;
        head_nx = pop ? head + TAG_W'(1) : head;
        tag_dist = resolve_tag - head;
        arch_nx = pop ? {ghr_arch[GHR_WIDTH-2:0], commit_taken} : ghr_arch;
        ghr_spec_nx = flush_all ? arch_nx :
                      mispredict ? {ckpt_rd[GHR_WIDTH-2:0], resolve_taken} :
                      push ? {ghr_spec[GHR_WIDTH-2:0], pred_taken} : ghr_spec;
        tail_nx = flush_all ? head_nx :
                  mispredict ? resolve_tag + TAG_W'(1) :
                  push ? tail + TAG_W'(1) : tail;
        count_nx = flush_all ? '0 :
                   (mispredict ? {1'b0, tag_dist} + CW'(1) : count + CW'(push)) - CW'(pop);
    end
    always_ff @(posedge clk)
        if (rst) begin
            ghr_spec <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            ghr_spec <= ghr_spec_nx;
            head <= head_nx;
            tail <= tail_nx;
            count <= count_nx;
            full <= count_nx == CW'(DEPTH);
            empty <= count_nx == '0;
        end
    ghr_ckpt_buf #(.W(GHR_WIDTH), .DEPTH(DEPTH)) u_buf (
        .clk(clk), .we(push), .waddr(tail), .wdata(ghr_spec),
        .raddr(resolve_tag), .rdata(ckpt_rd)
    );
    ghr_reg #(.W(GHR_WIDTH)) u_arch (
        .clk(clk), .rst(rst), .shift_en(pop), .din(commit_taken), .q(ghr_arch)
    );
    a_pred_hold: assert property (@(posedge clk) disable iff (rst) !(pred_valid && !pred_ready))
        else $warning("pred_valid while not ready");
    a_commit_empty: assert property (@(posedge clk) disable iff (rst) !(commit_valid && empty))
        else $warning("commit while empty");
    a_tag_in_flight: assert property (@(posedge clk) disable iff (rst) !resolve_valid || {1'b0, tag_dist} < count)
        else $warning("resolve_tag not in flight");
endmodule

// File: tb/tb_ghr_ctrl.sv
// tb_ghr_ctrl: table-driven directed check of ghr_ctrl at GHR_WIDTH=8, DEPTH=4
module tb_ghr_ctrl;
    logic clk, rst, pred_valid, pred_taken, pred_ready;
    logic [1:0] pred_tag, resolve_tag;
    logic resolve_valid, resolve_mispredict, resolve_taken;
    logic commit_valid, commit_taken, flush_all, full, empty;
    logic [7:0] ghr_spec, ghr_arch;
    logic [2:0] ckpt_count;
    int tests = 0, failed = 0;

    ghr_ctrl #(.GHR_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag), .resolve_valid(resolve_valid),
        .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
        .resolve_taken(resolve_taken), .commit_valid(commit_valid),
        .commit_taken(commit_taken), .flush_all(flush_all), .ghr_spec(ghr_spec),
        .ghr_arch(ghr_arch), .ckpt_count(ckpt_count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in = {rst, pv, pt, rv, rtag[1:0], rm, rt, cv, ct, flush}; rdy is sampled before the edge
    typedef struct {
        logic [10:0] in;
        logic        rdy;
        logic [1:0]  tag;
        logic [7:0]  spec;
        logic [7:0]  arch;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
    } vec_t;
    vec_t vecs[22];

    task automatic set_in(input logic [10:0] in);
        {rst, pred_valid, pred_taken, resolve_valid, resolve_tag, resolve_mispredict,
         resolve_taken, commit_valid, commit_taken, flush_all} = in;
    endtask

    task automatic drive(input logic [10:0] in);
        set_in(in);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rdy(input string name, input logic want);
        tests++;
        if (pred_ready !== want) begin
            failed++;
            $display("FAIL %s pred_ready: got %b want %b", name, pred_ready, want);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] tag, input logic [7:0] spec,
                               input logic [7:0] arch, input logic [2:0] cnt, input logic f, input logic e);
        tests++;
        if ({pred_tag, ghr_spec, ghr_arch, ckpt_count, full, empty} !== {tag, spec, arch, cnt, f, e}) begin
            failed++;
            $display("FAIL %s state: got tag=%0d spec=%h arch=%h cnt=%0d full=%b empty=%b, want tag=%0d spec=%h arch=%h cnt=%0d full=%b empty=%b",
                     name, pred_tag, ghr_spec, ghr_arch, ckpt_count, full, empty, tag, spec, arch, cnt, f, e);
        end
    endtask

    initial begin
        logic [7:0] pat;
        vecs[0]  = '{11'b1_0_0_0_00_0_0_0_0_0, 1'b1, 2'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd1, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{11'b0_1_0_0_00_0_0_0_0_0, 1'b1, 2'd2, 8'h02, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[3]  = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd3, 8'h05, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[4]  = '{11'b0_1_1_1_01_1_1_0_0_0, 1'b0, 2'd2, 8'h03, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[5]  = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd3, 8'h07, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[6]  = '{11'b0_1_0_0_00_0_0_0_0_0, 1'b1, 2'd0, 8'h0E, 8'h00, 3'd4, 1'b1, 1'b0};
        vecs[7]  = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b0, 2'd0, 8'h0E, 8'h00, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{11'b0_0_0_0_00_0_0_1_1_0, 1'b0, 2'd0, 8'h0E, 8'h01, 3'd3, 1'b0, 1'b0};
        vecs[9]  = '{11'b0_1_0_0_00_0_0_1_1_0, 1'b1, 2'd1, 8'h1C, 8'h03, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{11'b1_0_0_0_00_0_0_0_0_0, 1'b1, 2'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[11] = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd1, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd2, 8'h03, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[13] = '{11'b0_0_0_0_00_0_0_1_1_0, 1'b1, 2'd2, 8'h03, 8'h01, 3'd1, 1'b0, 1'b0};
        vecs[14] = '{11'b0_0_0_0_00_0_0_1_1_0, 1'b1, 2'd2, 8'h03, 8'h03, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{11'b0_0_0_0_00_0_0_1_1_0, 1'b1, 2'd2, 8'h03, 8'h03, 3'd0, 1'b0, 1'b1};
        vecs[16] = '{11'b0_1_0_0_00_0_0_0_0_0, 1'b1, 2'd3, 8'h06, 8'h03, 3'd1, 1'b0, 1'b0};
        vecs[17] = '{11'b0_1_1_0_00_0_0_0_0_0, 1'b1, 2'd0, 8'h0D, 8'h03, 3'd2, 1'b0, 1'b0};
        vecs[18] = '{11'b0_0_0_1_10_1_1_1_1_0, 1'b0, 2'd3, 8'h07, 8'h07, 3'd0, 1'b0, 1'b1};
        vecs[19] = '{11'b0_1_0_0_00_0_0_0_0_0, 1'b1, 2'd0, 8'h0E, 8'h07, 3'd1, 1'b0, 1'b0};
        vecs[20] = '{11'b0_1_1_1_11_0_0_0_0_0, 1'b1, 2'd1, 8'h1D, 8'h07, 3'd2, 1'b0, 1'b0};
        vecs[21] = '{11'b0_0_0_1_00_1_0_0_0_0, 1'b0, 2'd1, 8'h1C, 8'h07, 3'd2, 1'b0, 1'b0};

        set_in(11'b1_0_0_0_00_0_0_0_0_0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            set_in(vecs[i].in);
            #1;
            check_rdy($sformatf("vec%0d", i), vecs[i].rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].tag, vecs[i].spec, vecs[i].arch,
                        vecs[i].cnt, vecs[i].full, vecs[i].empty);
        end

        // build ghr_arch=A5 with one branch kept in flight, then 3 in flight and flush
        pat = 8'hA5;
        drive(11'b1_0_0_0_00_0_0_0_0_0);
        drive(11'b0_1_1_0_00_0_0_0_0_0);
        for (int i = 0; i < 8; i++)
            drive({1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, pat[7-i], 1'b0});
        drive(11'b0_1_0_0_00_0_0_0_0_0);
        drive(11'b0_1_0_0_00_0_0_0_0_0);
        check_state("pre_flush", 2'd3, 8'h00, 8'hA5, 3'd3, 1'b0, 1'b0);
        set_in(11'b0_0_0_0_00_0_0_1_0_1);
        #1;
        check_rdy("flush", 1'b0);
        @(posedge clk);
        #1;
        check_state("flush", 2'd1, 8'h4A, 8'h4A, 3'd0, 1'b0, 1'b1);

        drive(11'b0_1_1_0_00_0_0_0_0_0);
        drive(11'b0_1_1_0_00_0_0_0_0_0);
        check_state("pre_rst", 2'd3, 8'h2B, 8'h4A, 3'd2, 1'b0, 1'b0);
        drive(11'b1_1_1_0_00_0_0_1_1_0);
        check_state("mid_rst", 2'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        set_in(11'b0_0_0_0_00_0_0_0_0_0);
        #1;
        check_rdy("mid_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
